// File: rtl/vga_pkg.sv
// Shared constants, payload types and helpers for the parametrised VGA timing generator.
package vga_pkg;

  localparam int unsigned SYNC_NEG = 0;
  localparam int unsigned SYNC_POS = 1;

  // 640x480@60: 25 MHz pixel clock derived from a 50 MHz system clock.
  localparam int unsigned VGA640_CLK_DIV  = 2;
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FRONT  = 16;
  localparam int unsigned VGA640_H_PULSE  = 96;
  localparam int unsigned VGA640_H_BACK   = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FRONT  = 10;
  localparam int unsigned VGA640_V_PULSE  = 2;
  localparam int unsigned VGA640_V_BACK   = 33;
  localparam int unsigned VGA640_POL      = SYNC_NEG;

  // 800x600@72: pixel clock equals the 50 MHz system clock.
  localparam int unsigned SVGA800_CLK_DIV  = 1;
  localparam int unsigned SVGA800_H_ACTIVE = 800;
  localparam int unsigned SVGA800_H_FRONT  = 56;
  localparam int unsigned SVGA800_H_PULSE  = 120;
  localparam int unsigned SVGA800_H_BACK   = 64;
  localparam int unsigned SVGA800_V_ACTIVE = 600;
  localparam int unsigned SVGA800_V_FRONT  = 37;
  localparam int unsigned SVGA800_V_PULSE  = 6;
  localparam int unsigned SVGA800_V_BACK   = 23;
  localparam int unsigned SVGA800_POL      = SYNC_POS;

  // One pipeline stage of the video control signals, stored at output polarity.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic bright;
  } vid_ctrl_t;

  // Bits needed to hold value-1; used to size counters from totals.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = 32'(i + 1);
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus sync and active-region decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FRONT  = 16,
  parameter int unsigned PULSE  = 96,
  parameter int unsigned BACK   = 48,
  parameter int unsigned POL    = SYNC_NEG,
  parameter int unsigned CNT_W  = 10
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             syncLevel,
  output logic             active
);

  localparam int unsigned      EXT_W      = CNT_W + 1;
  localparam int unsigned      TOTAL      = ACTIVE + FRONT + PULSE + BACK;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [EXT_W-1:0] ACT_END    = EXT_W'(ACTIVE);
  localparam logic [EXT_W-1:0] SYNC_START = EXT_W'(ACTIVE + FRONT);
  localparam logic [EXT_W-1:0] SYNC_END   = EXT_W'(ACTIVE + FRONT + PULSE);
  localparam logic             ASSERT_LVL = (POL != 0);

  logic [CNT_W-1:0] count_q, count_d;
  logic [EXT_W-1:0] count_ext_c;
  logic             last_c;
  logic             in_pulse_c;

  assign last_c = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (step) count_d = last_c ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (clear) count_q <= '0;
    else       count_q <= count_d;
  end

  // Widened so parameter sums near the counter limit compare correctly.
  assign count_ext_c = {1'b0, count_q};
  assign in_pulse_c  = (count_ext_c >= SYNC_START) && (count_ext_c < SYNC_END);

  assign count     = count_q;
  assign wrap      = last_c;
  assign syncLevel = in_pulse_c ? ASSERT_LVL : ~ASSERT_LVL;
  assign active    = (count_ext_c < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA timing: pixel-enable divider, H/V axis counters,
// delayed sync/bright pipeline and line/frame strobes for the fetch logic.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV    = VGA640_CLK_DIV,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int unsigned H_FRONT    = VGA640_H_FRONT,
  parameter int unsigned H_PULSE    = VGA640_H_PULSE,
  parameter int unsigned H_BACK     = VGA640_H_BACK,
  parameter int unsigned V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int unsigned V_FRONT    = VGA640_V_FRONT,
  parameter int unsigned V_PULSE    = VGA640_V_PULSE,
  parameter int unsigned V_BACK     = VGA640_V_BACK,
  parameter int unsigned H_POL      = SYNC_NEG,
  parameter int unsigned V_POL      = SYNC_NEG,
  parameter int unsigned PIPE_DEPTH = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  output logic             pixEn,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic             lineEnd,
  output logic             frameEnd
);

  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int unsigned      CTRL_W   = $bits(vid_ctrl_t);
  localparam int unsigned      PIPE_W   = CTRL_W * PIPE_DEPTH;
  localparam vid_ctrl_t        CTRL_IDLE = '{hsync: (H_POL == 0), vsync: (V_POL == 0), bright: 1'b0};

  logic [DIV_W-1:0]  div_q, div_d;
  logic [PIPE_W-1:0] pipe_q, pipe_d;
  logic [PIPE_W-1:0] pipe_shift_c;
  logic              div_last_c;
  logic              pix_en_c;
  logic              v_step_c;
  logic              line_end_c;
  logic              frame_end_c;
  logic              h_wrap_c, v_wrap_c;
  logic              h_sync_c, v_sync_c;
  logic              h_act_c, v_act_c;
  vid_ctrl_t         stage_in_c;
  vid_ctrl_t         ctrl_out_c;

  // Pixel enable: last divider phase, suppressed while frozen or clearing.
  assign div_last_c = (div_q == DIV_LAST);
  assign pix_en_c   = enable && !clear && div_last_c;

  always_comb begin
    div_d = div_q;
    if (enable) div_d = div_last_c ? '0 : div_q + DIV_W'(1);
  end

  assign v_step_c = pix_en_c && h_wrap_c;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .PULSE  (H_PULSE),
    .BACK   (H_BACK),
    .POL    (H_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clock     (clock),
    .clear     (clear),
    .step      (pix_en_c),
    .count     (hCount),
    .wrap      (h_wrap_c),
    .syncLevel (h_sync_c),
    .active    (h_act_c)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .PULSE  (V_PULSE),
    .BACK   (V_BACK),
    .POL    (V_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clock     (clock),
    .clear     (clear),
    .step      (v_step_c),
    .count     (vCount),
    .wrap      (v_wrap_c),
    .syncLevel (v_sync_c),
    .active    (v_act_c)
  );

  assign stage_in_c = '{hsync: h_sync_c, vsync: v_sync_c, bright: h_act_c && v_act_c};

  // Newest stage enters at the bottom; the top stage drives the outputs.
  if (PIPE_DEPTH > 1) begin : g_shift
    assign pipe_shift_c = {pipe_q[PIPE_W-CTRL_W-1:0], stage_in_c};
  end else begin : g_single
    assign pipe_shift_c = stage_in_c;
  end

  always_comb begin
    pipe_d = pipe_q;
    if (pix_en_c) pipe_d = pipe_shift_c;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      div_q  <= '0;
      pipe_q <= {PIPE_DEPTH{CTRL_IDLE}};
    end else begin
      div_q  <= div_d;
      pipe_q <= pipe_d;
    end
  end

  assign ctrl_out_c  = pipe_q[PIPE_W-1 -: CTRL_W];
  assign line_end_c  = pix_en_c && h_wrap_c;
  assign frame_end_c = line_end_c && v_wrap_c;

  assign pixEn    = pix_en_c;
  assign hSync    = ctrl_out_c.hsync;
  assign vSync    = ctrl_out_c.vsync;
  assign bright   = ctrl_out_c.bright;
  assign lineEnd  = line_end_c;
  assign frameEnd = frame_end_c;

endmodule
